// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one add-and-shift per i_step, WIDTH steps per product.
// o_product_nxt is the product as it will stand after the current step.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_product_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum;

  // The extra top bit of w_sum holds the carry that shifts into the accumulator.
  assign w_sum         = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mcand} : '0);
  assign o_product_nxt = {w_sum[WIDTH:1], w_sum[0], r_q[WIDTH-1:1]};
  assign o_last        = (r_cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= i_mcand;
      r_q     <= i_mplier;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_step) begin
      r_acc   <= w_sum[WIDTH:1];
      r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/busy/done handshake, flag register and tristate bus output.
// Define ALU_MUL_EN to build in the multi-cycle shift-add multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  input  logic             start,
  input  logic             en,
  input  logic             flag_en,
  input  logic             flag_clr,
  output tri   [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             is_zero,
  output logic             negative,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  alu_state_t             r_state;
  logic [WIDTH-1:0]       r_result;
  logic [WIDTH-1:0]       r_result_hi;
  logic [NUM_FLAGS-1:0]   r_flags;
  logic                   r_done;

  alu_state_t             w_state_nxt;
  logic                   w_wr_result;
  logic [WIDTH-1:0]       w_res;
  logic [WIDTH-1:0]       w_res_hi;
  logic [NUM_FLAGS-1:0]   w_flags_new;

  logic [WIDTH:0]         w_ext;
  logic [WIDTH-1:0]       w_alu_res;
  logic                   w_alu_c;
  logic                   w_alu_v;
  logic [NUM_FLAGS-1:0]   w_alu_flags;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ext     = '0;
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        w_ext     = {1'b0, a} + {1'b0, b};
        w_alu_res = w_ext[WIDTH-1:0];
        w_alu_c   = w_ext[WIDTH];
        w_alu_v   = (a[MSB] == b[MSB]) && (w_alu_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_ext     = {1'b0, a} - {1'b0, b};
        w_alu_res = w_ext[WIDTH-1:0];
        w_alu_c   = w_ext[WIDTH];
        w_alu_v   = (a[MSB] != b[MSB]) && (w_alu_res[MSB] != a[MSB]);
      end
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SHL: begin
        w_alu_res = {a[WIDTH-2:0], 1'b0};
        w_alu_c   = a[MSB];
      end
      OP_SHR: begin
        w_alu_res = {1'b0, a[WIDTH-1:1]};
        w_alu_c   = a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_flags         = '0;
    w_alu_flags[FLAG_C] = w_alu_c;
    w_alu_flags[FLAG_Z] = (w_alu_res == '0);
    w_alu_flags[FLAG_N] = w_alu_res[MSB];
    w_alu_flags[FLAG_V] = w_alu_v;
  end

`ifdef ALU_MUL_EN
  logic                 w_mul_load;
  logic                 w_mul_step;
  logic                 w_mul_last;
  logic [2*WIDTH-1:0]   w_prod;
  logic [NUM_FLAGS-1:0] w_mul_flags;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk           (clk),
    .clr_n         (clr_n),
    .i_load        (w_mul_load),
    .i_step        (w_mul_step),
    .i_mcand       (a),
    .i_mplier      (b),
    .o_last        (w_mul_last),
    .o_product_nxt (w_prod)
  );

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_C] = (w_prod[2*WIDTH-1:WIDTH] != '0);
    w_mul_flags[FLAG_Z] = (w_prod == '0);
    w_mul_flags[FLAG_N] = w_prod[MSB];
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wr_result = 1'b0;
    w_res       = '0;
    w_res_hi    = '0;
    w_flags_new = '0;
`ifdef ALU_MUL_EN
    w_mul_load  = 1'b0;
    w_mul_step  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
`ifdef ALU_MUL_EN
            w_mul_load  = 1'b1;
            w_state_nxt = ST_MUL;
`else
            // Without the multiplier, MUL completes at once as a zero result.
            w_wr_result         = 1'b1;
            w_flags_new[FLAG_Z] = 1'b1;
`endif
          end else begin
            w_wr_result = 1'b1;
            w_res       = w_alu_res;
            w_flags_new = w_alu_flags;
          end
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        w_mul_step = 1'b1;
        if (w_mul_last) begin
          w_state_nxt = ST_IDLE;
          w_wr_result = 1'b1;
          w_res       = w_prod[WIDTH-1:0];
          w_res_hi    = w_prod[2*WIDTH-1:WIDTH];
          w_flags_new = w_mul_flags;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_wr_result;
      if (w_wr_result) begin
        r_result    <= w_res;
        r_result_hi <= w_res_hi;
      end
      if (flag_clr) begin
        r_flags <= '0;
      end else if (w_wr_result && flag_en) begin
        r_flags <= w_flags_new;
      end
    end
  end

  assign bus_out   = en ? r_result : {WIDTH{1'bz}};
  assign result_hi = r_result_hi;
  assign busy      = (r_state == ST_MUL);
  assign done      = r_done;
  assign carry     = r_flags[FLAG_C];
  assign is_zero   = r_flags[FLAG_Z];
  assign negative  = r_flags[FLAG_N];
  assign overflow  = r_flags[FLAG_V];

endmodule
